decimation: RTL

- 8-channel, 16-bit signed integrate-and-dump decimator; the receive-direction counterpart of the transmit interpolation path.
- Averages each group of R = 2^DEC_LOG2 valid input samples per channel. Emits one rounded 16-bit result per channel per group, with an output strobe.
- Sits between the 8-channel sample bus and the downstream capture/processing logic on the same 250 MHz clock.

---
 rtl/decimation.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/decimation.sv
// -----------------------------------------------------------------------------
// decimation
//
// Eight-channel integrate-and-dump decimator for 16-bit signed samples.
// Every group of R = 2**DEC_LOG2 valid input samples is summed per channel,
// rounded (half toward +inf) and divided by R with an arithmetic shift, giving
// one 16-bit result per channel per group together with a one-cycle strobe.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   valid        din0..din7 carry a new sample this cycle
//   sync         qualified by valid: this sample starts a new group
//   din0..din7   signed 16-bit input samples, one per channel
//   dout0..dout7 signed 16-bit decimated samples, registered, held between strobes
//   dout_valid   one-cycle strobe, dout0..dout7 updated this cycle
//
// Timing: inputs registered at edge N, result and strobe registered at edge N+1,
// i.e. outputs appear two cycles after the final sample of a group is applied.
// -----------------------------------------------------------------------------
module decimation #(
    parameter int DEC_LOG2 = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        sync,
    input  logic [15:0] din0,
    input  logic [15:0] din1,
    input  logic [15:0] din2,
    input  logic [15:0] din3,
    input  logic [15:0] din4,
    input  logic [15:0] din5,
    input  logic [15:0] din6,
    input  logic [15:0] din7,
    output logic [15:0] dout0,
    output logic [15:0] dout1,
    output logic [15:0] dout2,
    output logic [15:0] dout3,
    output logic [15:0] dout4,
    output logic [15:0] dout5,
    output logic [15:0] dout6,
    output logic [15:0] dout7,
    output logic        dout_valid
);

    localparam int R  = 1 << DEC_LOG2;
    localparam int AW = 16 + DEC_LOG2;
    localparam int CW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
    // R/2 is zero when R=1, so no rounding constant is added in that case.
    localparam logic signed [AW-1:0] RND = AW'(R / 2);

    logic signed [15:0]   w_din [8];
    logic signed [15:0]   r_din [8];
    logic signed [AW-1:0] r_acc [8];
    logic signed [15:0]   r_dout [8];

    logic          r_valid_q;
    logic          r_sync_q;
    logic [CW-1:0] r_cnt;
    logic          r_dout_valid;

    logic w_start;
    logic w_emit;
    logic w_accum;

    assign w_din[0] = din0;
    assign w_din[1] = din1;
    assign w_din[2] = din2;
    assign w_din[3] = din3;
    assign w_din[4] = din4;
    assign w_din[5] = din5;
    assign w_din[6] = din6;
    assign w_din[7] = din7;

    // A sync sample restarts the group and takes priority over completion.
    // With R=1 every sample completes a group, so sync has nothing to restart.
    assign w_start = r_valid_q && r_sync_q && (R > 1);
    assign w_emit  = r_valid_q && !w_start && ((R == 1) || (r_cnt == CW'(R - 1)));
    assign w_accum = r_valid_q && !w_start && !w_emit;

    // Shared control: input qualifiers, group counter and output strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q    <= 1'b0;
            r_sync_q     <= 1'b0;
            r_cnt        <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_valid_q    <= valid;
            r_sync_q     <= sync;
            r_dout_valid <= w_emit;
            if (w_start) begin
                r_cnt <= CW'(1);
            end else if (w_emit) begin
                r_cnt <= '0;
            end else if (w_accum) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Per-channel datapath, all channels in lock-step on the shared control.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ch
            logic signed [AW-1:0] w_ext;
            logic signed [AW-1:0] w_sum;
            logic signed [AW-1:0] w_rnd;
            logic signed [AW-1:0] w_shf;

            // Sum cannot overflow AW bits: |32768*R| fits in 16+DEC_LOG2 signed.
            assign w_ext = AW'(r_din[gi]);
            assign w_sum = r_acc[gi] + w_ext;
            assign w_rnd = w_sum + RND;
            assign w_shf = w_rnd >>> DEC_LOG2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_din[gi]  <= '0;
                    r_acc[gi]  <= '0;
                    r_dout[gi] <= '0;
                end else begin
                    r_din[gi] <= w_din[gi];
                    if (w_start) begin
                        r_acc[gi] <= w_ext;
                    end else if (w_emit) begin
                        r_acc[gi]  <= '0;
                        // The rounded mean always lies in the 16-bit range.
                        r_dout[gi] <= w_shf[15:0];
                    end else if (w_accum) begin
                        r_acc[gi] <= w_sum;
                    end
                end
            end
        end
    endgenerate

    assign dout0      = r_dout[0];
    assign dout1      = r_dout[1];
    assign dout2      = r_dout[2];
    assign dout3      = r_dout[3];
    assign dout4      = r_dout[4];
    assign dout5      = r_dout[5];
    assign dout6      = r_dout[6];
    assign dout7      = r_dout[7];
    assign dout_valid = r_dout_valid;

endmodule
